stepdown_corestate_seq: RTL and testbench

//   Switching-phase sequencer for the STEPDOWN core state logic. Turns the PWM request into
//   non-overlapping high-side/low-side gate enables with programmable dead time.

---
 rtl/stepdown_corestate_seq.sv | 193 +++++++++++++++++++
 tb/tb_stepdown_corestate_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/stepdown_corestate_seq.sv
// -----------------------------------------------------------------------------
// stepdown_corestate_seq
//
// Switching-phase sequencer for the STEPDOWN core state logic. It converts the
// PWM request into non-overlapping high-side / low-side gate enables with a
// programmable dead time. It also enforces a minimum on-time and a soft-start
// cap on the HS on-time, latches over-current faults, and shuts down on
// enable-low or UVLO.
//
// Optional feature macro: STEPDOWN_DIODE_EMU_EN
//   When defined, the zcd port exists. A zero-cross seen in LS with pwm low
//   parks the bridge in DCM, with both gates off, until the next pwm request.
//   When undefined, zcd is absent and LS is held until pwm returns.
//
// Ports
//   clk      in   core clock
//   rst      in   asynchronous reset, active-high
//   CELV     in   supply pin, no logic function
//   CELG     in   ground pin, no logic function
//   SUB      in   substrate pin, no logic function
//   en       in   converter enable
//   pwm      in   PWM request, 1 = HS on wanted
//   ocp      in   over-current fault
//   uvlo     in   under-voltage lockout, 1 = supply low
//   zcd      in   inductor zero-cross detect (STEPDOWN_DIODE_EMU_EN only)
//   hs_on    out  high-side gate enable
//   ls_on    out  low-side gate enable
//   pgood    out  soft-start complete
//   fault    out  latched OCP fault
//   state_o  out  state: OFF=0 HS=1 DT_HL=2 LS=3 DT_LH=4 FLT=5 DCM=6
// -----------------------------------------------------------------------------
module stepdown_corestate_seq #(
  parameter int CNT_W     = 8,
  parameter int DT_CYCLES = 3,
  parameter int MIN_ON    = 2,
  parameter int MAX_ON    = 200,
  parameter int SS_INIT   = 4,
  parameter int SS_STEP   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       CELV,
  input  logic       CELG,
  input  logic       SUB,
  input  logic       en,
  input  logic       pwm,
  input  logic       ocp,
  input  logic       uvlo,
`ifdef STEPDOWN_DIODE_EMU_EN
  input  logic       zcd,
`endif
  output logic       hs_on,
  output logic       ls_on,
  output logic       pgood,
  output logic       fault,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_HS    = 3'd1,
    S_DT_HL = 3'd2,
    S_LS    = 3'd3,
    S_DT_LH = 3'd4,
    S_FLT   = 3'd5,
    S_DCM   = 3'd6
  } state_t;

  // Segment compares are done one bit wider so that seg_cnt+1 cannot wrap
  // once the counter has saturated.
  localparam logic [CNT_W:0]   MIN_ON_C  = (CNT_W+1)'(MIN_ON);
  localparam logic [CNT_W:0]   DT_C      = (CNT_W+1)'(DT_CYCLES);
  localparam logic [CNT_W-1:0] MAX_ON_C  = CNT_W'(MAX_ON);
  localparam logic [CNT_W-1:0] SS_INIT_C = CNT_W'(SS_INIT);
  localparam int               SSP_W     = $clog2(SS_STEP + 1);
  localparam logic [SSP_W-1:0] SSP_LAST  = SSP_W'(SS_STEP - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] seg_cnt_q, seg_cnt_d;
  logic [CNT_W-1:0] on_lim_q, on_lim_d;
  logic [SSP_W-1:0] ss_pre_q, ss_pre_d;

  logic [CNT_W:0]   seg_inc;
  logic             min_ok;
  logic             dt_done;
  logic             ss_active;

  // The power pins only exist for netlist connectivity.
  logic unused_pwr;
  assign unused_pwr = ^{CELV, CELG, SUB};

  assign seg_inc   = {1'b0, seg_cnt_q} + 1'b1;
  assign min_ok    = (seg_inc >= MIN_ON_C);
  assign dt_done   = (seg_inc >= DT_C);
  assign ss_active = (state_q != S_OFF) && (state_q != S_FLT);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (state_q == S_FLT) begin
      // A latched fault is only released by dropping enable.
      if (!en) state_d = S_OFF;
    end else if (ocp) begin
      state_d = S_FLT;
    end else if (!en || uvlo) begin
      state_d = S_OFF;
    end else begin
      case (state_q)
        // Both gates are already off, so the first pulse needs no dead time.
        S_OFF:   if (pwm) state_d = S_HS;
        S_HS:    if ((!pwm && min_ok) || (seg_inc >= {1'b0, on_lim_q}))
                   state_d = S_DT_HL;
        S_DT_HL: if (dt_done) state_d = S_LS;
        S_LS: begin
          if (pwm && min_ok) state_d = S_DT_LH;
`ifdef STEPDOWN_DIODE_EMU_EN
          else if (zcd && min_ok && !pwm) state_d = S_DCM;
`endif
        end
        S_DT_LH: if (dt_done) state_d = S_HS;
`ifdef STEPDOWN_DIODE_EMU_EN
        // The LS gate is already off in DCM, so HS can follow directly.
        S_DCM:   if (pwm) state_d = S_HS;
`endif
        default: state_d = S_OFF;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Segment counter and soft-start ramp
  // ---------------------------------------------------------------------------
  always_comb begin
    seg_cnt_d = seg_cnt_q;
    if (state_d != state_q) begin
      seg_cnt_d = '0;
    end else if (seg_cnt_q != '1) begin
      seg_cnt_d = seg_cnt_q + 1'b1;
    end
  end

  always_comb begin
    on_lim_d = on_lim_q;
    ss_pre_d = ss_pre_q;
    if ((state_d == S_OFF) || (state_d == S_FLT)) begin
      // Every restart from OFF or FLT begins a fresh soft-start ramp.
      on_lim_d = SS_INIT_C;
      ss_pre_d = '0;
    end else if (ss_active) begin
      if (ss_pre_q == SSP_LAST) begin
        ss_pre_d = '0;
        if (on_lim_q < MAX_ON_C) on_lim_d = on_lim_q + 1'b1;
      end else begin
        ss_pre_d = ss_pre_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_OFF;
      seg_cnt_q <= '0;
      on_lim_q  <= SS_INIT_C;
      ss_pre_q  <= '0;
    end else begin
      state_q   <= state_d;
      seg_cnt_q <= seg_cnt_d;
      on_lim_q  <= on_lim_d;
      ss_pre_q  <= ss_pre_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore outputs
  // ---------------------------------------------------------------------------
  // Decoding the gates from a single state register guarantees that they are
  // never on together, and lets reset drop them without waiting for a clock.
  assign hs_on   = (state_q == S_HS);
  assign ls_on   = (state_q == S_LS);
  assign fault   = (state_q == S_FLT);
  assign pgood   = ss_active && (on_lim_q == MAX_ON_C);
  assign state_o = state_q;

  a_no_shoot_through : assert property (
    @(posedge clk) disable iff (rst) !(hs_on && ls_on)
  );

endmodule

// File: tb/tb_stepdown_corestate_seq.sv
module tb_stepdown_corestate_seq;

  logic       clk = 1'b0;
  logic       rst, CELV, CELG, SUB, en, pwm, ocp, uvlo;
`ifdef STEPDOWN_DIODE_EMU_EN
  logic       zcd;
`endif
  logic       hs_on, ls_on, pgood, fault;
  logic [2:0] state_o;

  int tests   = 0;
  int fails   = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  stepdown_corestate_seq dut (
    .clk     (clk),
    .rst     (rst),
    .CELV    (CELV),
    .CELG    (CELG),
    .SUB     (SUB),
    .en      (en),
    .pwm     (pwm),
    .ocp     (ocp),
    .uvlo    (uvlo),
`ifdef STEPDOWN_DIODE_EMU_EN
    .zcd     (zcd),
`endif
    .hs_on   (hs_on),
    .ls_on   (ls_on),
    .pgood   (pgood),
    .fault   (fault),
    .state_o (state_o)
  );

  always @(negedge clk) if (hs_on && ls_on) overlap++;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  typedef struct {
    logic       en, pwm, ocp, uvlo;
    logic       exp_hs, exp_ls;
    logic [2:0] exp_st;
  } vec_t;

  vec_t tbl[17];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Packs {hs, ls, pgood, fault, state} into one comparison.
  task automatic chk_out(input string nm, input logic hs, input logic ls,
                         input logic pg, input logic flt, input logic [2:0] st);
    check(nm, {25'd0, hs_on, ls_on, pgood, fault, state_o},
              {25'd0, hs, ls, pg, flt, st});
  endtask

  task automatic wait_st(input string nm, input logic [2:0] target, input int bound);
    for (int n = 0; n < bound && state_o != target; n++) step();
    check(nm, state_o, target);
  endtask

  logic [2:0] pulse_st[9] = '{3'd4, 3'd4, 3'd4, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3};
  logic       pulse_hs[9] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
  logic       pulse_ls[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    int first_pg;
    int cnt;

    // en, pwm, ocp, uvlo, hs, ls, state: pwm held high from OFF, SS cap = 4
    tbl[0]  = '{1, 1, 0, 0, 1, 0, 3'd1};
    tbl[1]  = '{1, 1, 0, 0, 1, 0, 3'd1};
    tbl[2]  = '{1, 1, 0, 0, 1, 0, 3'd1};
    tbl[3]  = '{1, 1, 0, 0, 1, 0, 3'd1};
    tbl[4]  = '{1, 1, 0, 0, 0, 0, 3'd2};
    tbl[5]  = '{1, 1, 0, 0, 0, 0, 3'd2};
    tbl[6]  = '{1, 1, 0, 0, 0, 0, 3'd2};
    tbl[7]  = '{1, 1, 0, 0, 0, 1, 3'd3};
    tbl[8]  = '{1, 1, 0, 0, 0, 1, 3'd3};
    tbl[9]  = '{1, 1, 0, 0, 0, 0, 3'd4};
    tbl[10] = '{1, 1, 0, 0, 0, 0, 3'd4};
    tbl[11] = '{1, 1, 0, 0, 0, 0, 3'd4};
    tbl[12] = '{1, 1, 0, 0, 1, 0, 3'd1};
    tbl[13] = '{1, 1, 0, 0, 1, 0, 3'd1};
    tbl[14] = '{1, 1, 0, 0, 1, 0, 3'd1};
    tbl[15] = '{1, 1, 0, 0, 1, 0, 3'd1};
    tbl[16] = '{1, 1, 0, 0, 0, 0, 3'd2};

    rst = 1'b1; CELV = 1'b1; CELG = 1'b0; SUB = 1'b0;
    en = 1'b0; pwm = 1'b0; ocp = 1'b0; uvlo = 1'b0;
`ifdef STEPDOWN_DIODE_EMU_EN
    zcd = 1'b0;
`endif
    step(); step();
    chk_out("reset", 0, 0, 0, 0, 3'd0);
    rst = 1'b0;
    step();
    chk_out("idle_en_low", 0, 0, 0, 0, 3'd0);

    // Basic switching cycle under the initial soft-start cap
    for (int i = 0; i < 17; i++) begin
      en = tbl[i].en; pwm = tbl[i].pwm; ocp = tbl[i].ocp; uvlo = tbl[i].uvlo;
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].exp_hs, tbl[i].exp_ls, 1'b0, 1'b0, tbl[i].exp_st);
    end

    // OCP during HS latches a fault that ignores pwm/uvlo/ocp until en drops
    wait_st("reach_hs_for_ocp", 3'd1, 40);
    ocp = 1'b1;
    step();
    chk_out("ocp_in_hs", 0, 0, 0, 1, 3'd5);
    ocp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pwm  = k[0];
      uvlo = (k == 2);
      step();
      chk_out($sformatf("flt_hold%0d", k), 0, 0, 0, 1, 3'd5);
    end
    uvlo = 1'b0;
    en = 1'b0;
    step();
    chk_out("flt_release", 0, 0, 0, 0, 3'd0);

    // Enable with pwm low stays OFF; en low shuts HS down
    en = 1'b1; pwm = 1'b0;
    step();
    chk_out("off_pwm_low", 0, 0, 0, 0, 3'd0);
    pwm = 1'b1;
    step();
    chk_out("off_to_hs", 1, 0, 0, 0, 3'd1);
    en = 1'b0;
    step();
    chk_out("en_low_shutdown", 0, 0, 0, 0, 3'd0);

    // Soft-start ramp: on_lim 4 -> 200 at one step per 16 active cycles
    en = 1'b1; pwm = 1'b1;
    first_pg = -1;
    for (int i = 0; i < 5000; i++) begin
      step();
      if (i == 0) chk_out("ramp_start", 1, 0, 0, 0, 3'd1);
      if (pgood && first_pg < 0) begin
        first_pg = i;
        break;
      end
    end
    check("pgood_cycle", first_pg, 3136);

    // pwm held high after pgood: HS capped at MAX_ON, then dead time, then LS
    wait_st("reach_dtlh", 3'd4, 300);
    wait_st("reach_hs_full", 3'd1, 10);
    cnt = 0;
    while (state_o == 3'd1 && cnt < 300) begin cnt++; step(); end
    check("hs_max_on_len", cnt, 200);
    cnt = 0;
    while (state_o == 3'd2 && cnt < 20) begin cnt++; step(); end
    check("dt_hl_len", cnt, 3);
    cnt = 0;
    while (state_o == 3'd3 && cnt < 20) begin cnt++; step(); end
    check("ls_min_on_len", cnt, 2);

    // Single-cycle pwm pulse after pgood: HS stretched to MIN_ON
    wait_st("reach_ls", 3'd3, 300);
    pwm = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out($sformatf("ls_hold%0d", k), 0, 1, 1, 0, 3'd3);
    end
    pwm = 1'b1;
    step();
    chk_out("pulse0", pulse_hs[0], pulse_ls[0], 1, 0, pulse_st[0]);
    pwm = 1'b0;
    for (int k = 1; k < 9; k++) begin
      step();
      chk_out($sformatf("pulse%0d", k), pulse_hs[k], pulse_ls[k], 1, 0, pulse_st[k]);
    end

    // UVLO for one cycle in LS
    uvlo = 1'b1;
    step();
    chk_out("uvlo_in_ls", 0, 0, 0, 0, 3'd0);
    uvlo = 1'b0;

`ifdef STEPDOWN_DIODE_EMU_EN
    // Diode emulation: zero-cross in LS with pwm low parks in DCM
    pwm = 1'b1;
    wait_st("dcm_reach_ls", 3'd3, 30);
    pwm = 1'b0; zcd = 1'b1;
    step();
    chk_out("dcm_min_on", 0, 1, 0, 0, 3'd3);
    step();
    chk_out("dcm_enter", 0, 0, 0, 0, 3'd6);
    zcd = 1'b0; pwm = 1'b1;
    step();
    chk_out("dcm_to_hs", 1, 0, 0, 0, 3'd1);
`endif

    // Asynchronous reset in the middle of an HS pulse
    en = 1'b1; pwm = 1'b1;
    wait_st("reach_hs_for_rst", 3'd1, 30);
    #2 rst = 1'b1;
    #1;
    chk_out("async_rst_mid_pulse", 0, 0, 0, 0, 3'd0);
    step();
    rst = 1'b0;
    step();
    chk_out("after_rst_restart", 1, 0, 0, 0, 3'd1);

    check("no_shoot_through", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
